regfile_wb_scheduler: RTL and testbench
=======================================

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all state on rising edge
  rst  in  1  asynchronous, active-low reset
  a_valid  in  1  ALU writeback request
  a_rd  in  5  ALU destination register
  a_data  in  32  ALU result
  a_ready  out  1  ALU request granted this cycle
  m_valid  in  1  load-unit writeback request
  m_rd  in  5  load destination register
  m_data  in  32  load data
  m_ready  out  1  load request granted this cycle
  iss_valid  in  1  issue stage reserving a destination
  iss_rd  in  5  destination being reserved
  iss_stall  out  1  reservation refused this cycle
  regwrite  out  1  register-file write enable
  writereg  out  5  register-file write index
  writedata  out  32  register-file write data
  busy  out  32  per-register pending-write scoreboard

Function
REQ-002 The block SHALL grant at most one requester per cycle; a request is accepted when its valid and ready are both high.
REQ-003 a_ready and m_ready SHALL be combinational from the valids and the arbitration state, and SHALL never be high together.
REQ-004 A requester with valid low SHALL never receive ready.
REQ-005 With one valid requester, that requester SHALL be granted in the same cycle.
REQ-006 With both valid, the block SHALL grant the requester not granted most recently (round-robin). The last-granted pointer SHALL update on every grant.
REQ-007 On a grant with rd != 0, the next cycle SHALL show regwrite=1, writereg=rd and writedata=data. Latency is exactly 1 cycle.
REQ-008 On a grant with rd == 0, the request SHALL be accepted and SHALL update the pointer, but regwrite SHALL be 0 the next cycle.
REQ-009 In a cycle with no grant, the next cycle SHALL show regwrite=0, and writereg and writedata SHALL hold their previous values.
REQ-010 busy[n] SHALL be set at the edge where iss_valid=1, iss_stall=0 and iss_rd=n, for n != 0.
REQ-011 busy[n] SHALL be cleared at the edge where a grant with rd=n is taken; busy drops in the same cycle regwrite rises.
REQ-012 iss_stall SHALL be iss_valid AND busy[iss_rd], using registered busy. A reservation of a register that is clearing at this edge SHALL still stall.
REQ-013 A set and a clear on different indices at the same edge SHALL both take effect.
REQ-014 busy[0] SHALL be constant 0, and iss_stall SHALL be 0 for iss_rd=0.
REQ-015 A grant whose rd has busy=0 SHALL still write; the scoreboard SHALL only gate reservations, never writebacks.
REQ-016 A valid request held while not granted SHALL keep its rd and data stable until accepted; the block need not check this.

Reset
REQ-017 While rst=0, the block SHALL hold regwrite=0, writereg=0, writedata=0 and busy=0, and the pointer SHALL be set to "load last" so the ALU wins the first conflict.
REQ-018 Reset SHALL take effect immediately, without a clock edge. Any output-stage write in flight SHALL be dropped, and all readies SHALL be 0 while rst=0.
REQ-019 The first grant SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-020 With macro WB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: the load unit always wins over the ALU, and the pointer SHALL be removed.
REQ-021 Without WB_FIXED_PRIO_EN, the round-robin of REQ-006 SHALL apply. All other requirements are unchanged by the macro.

Verification
REQ-022 Reset, then a_valid=1, a_rd=5, a_data=0x11 for one cycle -> a_ready=1 that cycle; next cycle regwrite=1, writereg=5, writedata=0x11.
REQ-023 Both valid for 4 cycles, a_rd=3 and m_rd=4 with fresh data each cycle -> grants A,M,A,M; writereg sequence 3,4,3,4, each one cycle after its grant. With WB_FIXED_PRIO_EN: grants M,M,M,M.
REQ-024 iss_valid=1, iss_rd=7 -> busy[7]=1 next cycle. Repeat iss_rd=7 -> iss_stall=1. Then m_valid=1, m_rd=7 -> busy[7]=0 and regwrite=1 on the same cycle.
REQ-025 a_valid=1, a_rd=0, a_data=0xFFFF_FFFF -> a_ready=1, and regwrite stays 0 the next cycle. iss_rd=0 -> iss_stall=0 and busy stays 0.
REQ-026 Drive rst low mid-cycle between a grant and its write -> regwrite=0 and busy=0 immediately. After release, conflicting requests -> ALU granted first.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback bus shared by the ALU, the load unit, the issue stage and the
// register file. The scheduler sits on the slave side.
interface regfile_wb_scheduler_if;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_stall;
  logic        regwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic [31:0] busy;

  modport master (
    output a_valid, a_rd, a_data, m_valid, m_rd, m_data, iss_valid, iss_rd,
    input  a_ready, m_ready, iss_stall, regwrite, writereg, writedata, busy
  );

  modport slave (
    input  a_valid, a_rd, a_data, m_valid, m_rd, m_data, iss_valid, iss_rd,
    output a_ready, m_ready, iss_stall, regwrite, writereg, writedata, busy
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Two-source register-file writeback arbiter with a pending-write scoreboard.
// WB_FIXED_PRIO_EN: load unit always wins; default is round-robin.
module regfile_wb_scheduler (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_scheduler_if.slave  bus
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  wb_req_t           a_req, m_req, g_req;
  logic              a_gnt, m_gnt, grant;
  logic [STAGES:0]   vld_pipe;
  logic [4:0]        wr_rd;
  logic [31:0]       wr_data;
  logic [31:0]       busy_q, set_mask, clr_mask;
  logic              stall;

  assign a_req = '{rd: bus.a_rd, data: bus.a_data};
  assign m_req = '{rd: bus.m_rd, data: bus.m_data};

`ifdef WB_FIXED_PRIO_EN
  assign m_gnt = rst & bus.m_valid;
  assign a_gnt = rst & bus.a_valid & ~bus.m_valid;
`else
  logic last_m;

  // On conflict, the side that did not win last time goes.
  assign a_gnt = rst & bus.a_valid & (~bus.m_valid | last_m);
  assign m_gnt = rst & bus.m_valid & (~bus.a_valid | ~last_m);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_m <= 1'b1;
    else if (m_gnt) last_m <= 1'b1;
    else if (a_gnt) last_m <= 1'b0;
  end
`endif

  assign grant       = a_gnt | m_gnt;
  assign g_req       = m_gnt ? m_req : a_req;
  assign vld_pipe[0] = grant & (g_req.rd != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe[STAGES:1] <= '0;
      wr_rd              <= '0;
      wr_data            <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) begin
        wr_rd   <= g_req.rd;
        wr_data <= g_req.data;
      end
    end
  end

  // Stall looks at registered busy only, so a register clearing this edge
  // still refuses a new reservation.
  assign stall    = bus.iss_valid & busy_q[bus.iss_rd];
  assign set_mask = (bus.iss_valid & ~stall) ? (32'd1 << bus.iss_rd) : 32'd0;
  assign clr_mask = vld_pipe[0] ? (32'd1 << g_req.rd) : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  assign bus.a_ready   = a_gnt;
  assign bus.m_ready   = m_gnt;
  assign bus.iss_stall = stall;
  assign bus.regwrite  = vld_pipe[STAGES];
  assign bus.writereg  = wr_rd;
  assign bus.writedata = wr_data;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration, write latency,
// scoreboard set/clear/stall, rd=0 handling and asynchronous reset.
module tb_regfile_wb_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  regfile_wb_scheduler_if bus();

  regfile_wb_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef WB_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.m_valid = 0; bus.m_rd = 0; bus.m_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    @(negedge clk);
    rst = 0;
    #2;
    rst = 1;
    #1;
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.a_valid = 1; bus.a_rd = 5'd4; bus.m_valid = 1; bus.m_rd = 5'd8;
    #3;
    n_cmp++; if (bus.a_ready !== 1'b0) begin n_err++; $display("FAIL rst_a_ready got %b want 0", bus.a_ready); end
    n_cmp++; if (bus.m_ready !== 1'b0) begin n_err++; $display("FAIL rst_m_ready got %b want 0", bus.m_ready); end
    tick();
    n_cmp++; if (bus.regwrite !== 1'b0) begin n_err++; $display("FAIL rst_regwrite got %b want 0", bus.regwrite); end
    n_cmp++; if (bus.writereg !== 5'd0) begin n_err++; $display("FAIL rst_writereg got %0d want 0", bus.writereg); end
    n_cmp++; if (bus.writedata !== 32'd0) begin n_err++; $display("FAIL rst_writedata got %h want 0", bus.writedata); end
    n_cmp++; if (bus.busy !== 32'd0) begin n_err++; $display("FAIL rst_busy got %h want 0", bus.busy); end
    idle_inputs();
    @(negedge clk);
    rst = 1;
    #1;
  endtask

  task automatic test_single;
    bus.a_valid = 1; bus.a_rd = 5'd5; bus.a_data = 32'h11;
    #1;
    n_cmp++; if (bus.a_ready !== 1'b1) begin n_err++; $display("FAIL single_a_ready got %b want 1", bus.a_ready); end
    n_cmp++; if (bus.m_ready !== 1'b0) begin n_err++; $display("FAIL single_m_ready got %b want 0", bus.m_ready); end
    tick();
    bus.a_valid = 0;
    n_cmp++; if (bus.regwrite !== 1'b1) begin n_err++; $display("FAIL single_regwrite got %b want 1", bus.regwrite); end
    n_cmp++; if (bus.writereg !== 5'd5) begin n_err++; $display("FAIL single_writereg got %0d want 5", bus.writereg); end
    n_cmp++; if (bus.writedata !== 32'h11) begin n_err++; $display("FAIL single_writedata got %h want 11", bus.writedata); end
    tick();
    n_cmp++; if (bus.regwrite !== 1'b0) begin n_err++; $display("FAIL idle_regwrite got %b want 0", bus.regwrite); end
    n_cmp++; if (bus.writereg !== 5'd5 || bus.writedata !== 32'h11)
      begin n_err++; $display("FAIL idle_hold got %0d/%h want 5/11", bus.writereg, bus.writedata); end
  endtask

  task automatic test_back_to_back;
    logic        exp_a;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    do_reset();
    bus.a_valid = 1; bus.m_valid = 1; bus.a_rd = 5'd3; bus.m_rd = 5'd4;
    for (int i = 0; i < 4; i++) begin
      bus.a_data = 32'h100 + i;
      bus.m_data = 32'h200 + i;
      exp_a    = RR && (i % 2 == 0);
      exp_rd   = exp_a ? 5'd3 : 5'd4;
      exp_data = exp_a ? 32'h100 + i : 32'h200 + i;
      #1;
      n_cmp++; if (bus.a_ready !== exp_a || bus.m_ready !== !exp_a)
        begin n_err++; $display("FAIL arb_%0d got a=%b m=%b want a=%b", i, bus.a_ready, bus.m_ready, exp_a); end
      tick();
      n_cmp++; if (bus.regwrite !== 1'b1 || bus.writereg !== exp_rd || bus.writedata !== exp_data)
        begin n_err++; $display("FAIL arb_wr_%0d got %b/%0d/%h want 1/%0d/%h", i, bus.regwrite, bus.writereg, bus.writedata, exp_rd, exp_data); end
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard;
    bus.iss_valid = 1; bus.iss_rd = 5'd7;
    #1;
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_err++; $display("FAIL sb_first_stall got %b want 0", bus.iss_stall); end
    tick();
    n_cmp++; if (bus.busy !== 32'h80) begin n_err++; $display("FAIL sb_set got %h want 80", bus.busy); end
    n_cmp++; if (bus.iss_stall !== 1'b1) begin n_err++; $display("FAIL sb_repeat_stall got %b want 1", bus.iss_stall); end
    bus.m_valid = 1; bus.m_rd = 5'd7; bus.m_data = 32'hABCD;
    #1;
    n_cmp++; if (bus.iss_stall !== 1'b1 || bus.m_ready !== 1'b1)
      begin n_err++; $display("FAIL sb_clear_edge got stall=%b m_ready=%b want 1/1", bus.iss_stall, bus.m_ready); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.busy !== 32'h0 || bus.regwrite !== 1'b1 || bus.writereg !== 5'd7 || bus.writedata !== 32'hABCD)
      begin n_err++; $display("FAIL sb_clear got busy=%h wr=%b/%0d/%h want 0/1/7/abcd", bus.busy, bus.regwrite, bus.writereg, bus.writedata); end
    bus.iss_valid = 1; bus.iss_rd = 5'd3;
    tick();
    bus.iss_rd = 5'd9; bus.a_valid = 1; bus.a_rd = 5'd3; bus.a_data = 32'h33;
    tick();
    idle_inputs();
    n_cmp++; if (bus.busy !== 32'h200 || bus.regwrite !== 1'b1 || bus.writereg !== 5'd3)
      begin n_err++; $display("FAIL sb_set_clr got busy=%h wr=%b/%0d want 200/1/3", bus.busy, bus.regwrite, bus.writereg); end
  endtask

  task automatic test_rd0;
    bus.m_valid = 1; bus.m_rd = 5'd13; bus.m_data = 32'h1234;
    tick();
    idle_inputs();
    n_cmp++; if (bus.regwrite !== 1'b1 || bus.writereg !== 5'd13)
      begin n_err++; $display("FAIL free_write got %b/%0d want 1/13", bus.regwrite, bus.writereg); end
    bus.a_valid = 1; bus.a_rd = 5'd0; bus.a_data = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (bus.a_ready !== 1'b1) begin n_err++; $display("FAIL rd0_ready got %b want 1", bus.a_ready); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.regwrite !== 1'b0 || bus.writereg !== 5'd13 || bus.writedata !== 32'h1234)
      begin n_err++; $display("FAIL rd0_nowrite got %b/%0d/%h want 0/13/1234", bus.regwrite, bus.writereg, bus.writedata); end
    // rd=0 grant still moved the pointer to "ALU last"
    bus.a_valid = 1; bus.m_valid = 1; bus.a_rd = 5'd1; bus.m_rd = 5'd2;
    #1;
    n_cmp++; if (bus.m_ready !== 1'b1 || bus.a_ready !== 1'b0)
      begin n_err++; $display("FAIL rd0_ptr got a=%b m=%b want a=0 m=1", bus.a_ready, bus.m_ready); end
    tick();
    idle_inputs();
    bus.iss_valid = 1; bus.iss_rd = 5'd0;
    #1;
    n_cmp++; if (bus.iss_stall !== 1'b0) begin n_err++; $display("FAIL rd0_stall got %b want 0", bus.iss_stall); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.busy !== 32'h200) begin n_err++; $display("FAIL rd0_busy got %h want 200", bus.busy); end
  endtask

  task automatic test_midreset;
    logic exp_a;
    bus.a_valid = 1; bus.a_rd = 5'd6; bus.a_data = 32'h66;
    tick();
    n_cmp++; if (bus.regwrite !== 1'b1) begin n_err++; $display("FAIL pre_rst_write got %b want 1", bus.regwrite); end
    rst = 0;
    #1;
    n_cmp++; if (bus.regwrite !== 1'b0 || bus.busy !== 32'h0 || bus.writereg !== 5'd0 || bus.a_ready !== 1'b0)
      begin n_err++; $display("FAIL async_rst got wr=%b busy=%h reg=%0d a_ready=%b want 0/0/0/0", bus.regwrite, bus.busy, bus.writereg, bus.a_ready); end
    idle_inputs();
    @(negedge clk);
    rst = 1;
    bus.a_valid = 1; bus.m_valid = 1; bus.a_rd = 5'd1; bus.m_rd = 5'd2;
    bus.a_data = 32'hA1; bus.m_data = 32'hB2;
    exp_a = RR;
    #1;
    n_cmp++; if (bus.a_ready !== exp_a || bus.m_ready !== !exp_a)
      begin n_err++; $display("FAIL post_rst_arb got a=%b m=%b want a=%b", bus.a_ready, bus.m_ready, exp_a); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.regwrite !== 1'b1 || bus.writereg !== (exp_a ? 5'd1 : 5'd2))
      begin n_err++; $display("FAIL post_rst_wr got %b/%0d want 1/%0d", bus.regwrite, bus.writereg, exp_a ? 1 : 2); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_scoreboard();
    test_rd0();
    test_midreset();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
